// File: rtl/adc16dv160_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// adc16dv160_input_common
//   Shared types and helpers for the ADC16DV160 input path.
//   - cap_state_t : capture sequencer state encoding
//   - thr_ge      : threshold compare (a >= b), signed or unsigned 16-bit,
//                   used by any logic that tests samples against a threshold
// ---------------------------------------------------------------------------
package adc16dv160_input_common;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARM     = 2'd1,
    CAP_CAPTURE = 2'd2
  } cap_state_t;

  localparam int SAMPLE_W = 16;
  localparam int COUNT_W  = 32;

  function automatic logic thr_ge(input logic [SAMPLE_W-1:0] a,
                                  input logic [SAMPLE_W-1:0] b,
                                  input logic                signed_cmp);
    logic signed [SAMPLE_W-1:0] sa;
    logic signed [SAMPLE_W-1:0] sb;
    sa = a;
    sb = b;
    if (signed_cmp) thr_ge = (sa >= sb);
    else            thr_ge = (a >= b);
  endfunction

endpackage

// File: rtl/adc16dv160_capture_ctrl_run.sv
// ---------------------------------------------------------------------------
// adc16dv160_run_counter
//   Counts consecutive qualifying samples. Each enabled sample either extends
//   the run (hit=1) or restarts it (hit=0). done flags, combinationally, the
//   sample that makes the run reach max(n,1). The count saturates at all-ones.
// Ports
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   clr           : restart the run (wins over en)
//   en            : a sample is being evaluated this cycle
//   hit           : the sample meets the run condition
//   n             : required run length (0 treated as 1)
//   done          : this sample completes the run
// ---------------------------------------------------------------------------
module adc16dv160_run_counter
  import adc16dv160_input_common::*;
(
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               clr,
  input  logic               en,
  input  logic               hit,
  input  logic [COUNT_W-1:0] n,
  output logic               done
);

  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_inc;
  logic [COUNT_W-1:0] n_eff;

  assign n_eff   = (n == '0) ? COUNT_W'(1) : n;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + COUNT_W'(1);
  assign done    = en && hit && (cnt_inc >= n_eff);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= hit ? cnt_inc : '0;
    end
  end

endmodule

// File: rtl/adc16dv160_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc16dv160_capture_ctrl
//   Capture sequencer between the ADC16DV160 sample input and the AXI-Stream
//   DMA path. Frames of dsize samples, single-shot or continuous, with an
//   optional level-sync trigger/stop and a test-pattern source.
// Ports
//   ACLK, ARESETN          : clock, asynchronous active-low reset
//   cr_start               : 1-cycle start pulse
//   cr_test, cr_rt, cr_ls  : test pattern / continuous / level-sync
//   dsize                  : frame length in samples
//   ls_start_thr/stop_thr  : level-sync thresholds
//   ls_n_start/n_stop      : required run lengths
//   adc_data, adc_valid    : ADC sample and strobe (no backpressure)
//   m_tdata/tvalid/tready/tlast : stream output, 1-deep register
//   busy                   : sequencer not idle
//   overflow               : sticky, a sample was dropped on backpressure
// ---------------------------------------------------------------------------
module adc16dv160_capture_ctrl
  import adc16dv160_input_common::*;
#(
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cr_start,
  input  logic                cr_test,
  input  logic                cr_rt,
  input  logic                cr_ls,
  input  logic [COUNT_W-1:0]  dsize,
  input  logic [SAMPLE_W-1:0] ls_start_thr,
  input  logic [SAMPLE_W-1:0] ls_stop_thr,
  input  logic [COUNT_W-1:0]  ls_n_start,
  input  logic [COUNT_W-1:0]  ls_n_stop,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  output logic [SAMPLE_W-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                busy,
  output logic                overflow
);

  cap_state_t          state;
  cap_state_t          state_nxt;

  logic [COUNT_W-1:0]  dsize_q;
  logic [COUNT_W-1:0]  n_start_q;
  logic [COUNT_W-1:0]  n_stop_q;
  logic [SAMPLE_W-1:0] start_thr_q;
  logic [SAMPLE_W-1:0] stop_thr_q;
  logic                ls_q;
  logic                test_q;
  logic [COUNT_W-1:0]  frame_cnt;
  logic [SAMPLE_W-1:0] pattern;

  logic [SAMPLE_W-1:0] s;
  logic                start_acc;
  logic                start_hit;
  logic                stop_hit;
  logic                arm_en;
  logic                start_done;
  logic                stop_en;
  logic                stop_done;
  logic                run_clr;
  logic                frame_sample;
  logic                eof;
  logic                out_free;

  assign s         = test_q ? pattern : adc_data;
  assign start_acc = (state == CAP_IDLE) && cr_start && (dsize != '0);
  assign start_hit = thr_ge(s, start_thr_q, SIGNED_CMP);
  assign stop_hit  = !thr_ge(s, stop_thr_q, SIGNED_CMP);
  assign arm_en    = (state == CAP_ARM) && adc_valid;

  // The triggering ARM sample is itself frame sample 0.
  assign frame_sample = adc_valid &&
                        ((state == CAP_CAPTURE) || ((state == CAP_ARM) && start_done));
  assign stop_en = frame_sample && ls_q;
  assign eof     = frame_sample &&
                   ((frame_cnt == dsize_q - COUNT_W'(1)) || (ls_q && stop_done));
  assign run_clr = start_acc || eof;

  adc16dv160_run_counter u_start_run (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clr     (run_clr),
    .en      (arm_en),
    .hit     (start_hit),
    .n       (n_start_q),
    .done    (start_done)
  );

  adc16dv160_run_counter u_stop_run (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clr     (run_clr),
    .en      (stop_en),
    .hit     (stop_hit),
    .n       (n_stop_q),
    .done    (stop_done)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= CAP_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != CAP_IDLE);
    case (state)
      CAP_IDLE: begin
        if (start_acc) state_nxt = cr_ls ? CAP_ARM : CAP_CAPTURE;
      end
      CAP_ARM, CAP_CAPTURE: begin
        // cr_rt is only looked at when a frame ends.
        if (eof) begin
          if (cr_rt) state_nxt = ls_q ? CAP_ARM : CAP_CAPTURE;
          else       state_nxt = CAP_IDLE;
        end else if ((state == CAP_ARM) && start_done) begin
          state_nxt = CAP_CAPTURE;
        end
      end
      default: state_nxt = CAP_IDLE;
    endcase
  end

  // Configuration snapshot taken at start
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dsize_q     <= '0;
      n_start_q   <= '0;
      n_stop_q    <= '0;
      start_thr_q <= '0;
      stop_thr_q  <= '0;
      ls_q        <= 1'b0;
      test_q      <= 1'b0;
    end else if (start_acc) begin
      dsize_q     <= dsize;
      n_start_q   <= ls_n_start;
      n_stop_q    <= ls_n_stop;
      start_thr_q <= ls_start_thr;
      stop_thr_q  <= ls_stop_thr;
      ls_q        <= cr_ls;
      test_q      <= cr_test;
    end
  end

  // Frame position and test pattern
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame_cnt <= '0;
      pattern   <= '0;
    end else begin
      if (start_acc)         frame_cnt <= '0;
      else if (frame_sample) frame_cnt <= eof ? '0 : frame_cnt + COUNT_W'(1);

      if (start_acc)      pattern <= '0;
      else if (adc_valid) pattern <= pattern + SAMPLE_W'(1);
    end
  end

  // Output stage: 1-deep register; a sample that finds it full and stalled is dropped
  assign out_free = !m_tvalid || m_tready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (frame_sample && out_free) begin
        m_tdata  <= s;
        m_tvalid <= 1'b1;
        m_tlast  <= eof;
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end

      if (start_acc)                      overflow <= 1'b0;
      else if (frame_sample && !out_free) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc16dv160_capture_ctrl.sv
module tb_adc16dv160_capture_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cr_start = 1'b0;
  logic        cr_test = 1'b0;
  logic        cr_rt = 1'b0;
  logic        cr_ls = 1'b0;
  logic [31:0] dsize = '0;
  logic [15:0] ls_start_thr = '0;
  logic [15:0] ls_stop_thr = '0;
  logic [31:0] ls_n_start = '0;
  logic [31:0] ls_n_stop = '0;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  adc16dv160_capture_ctrl #(.SIGNED_CMP(1'b1)) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .cr_start     (cr_start),
    .cr_test      (cr_test),
    .cr_rt        (cr_rt),
    .cr_ls        (cr_ls),
    .dsize        (dsize),
    .ls_start_thr (ls_start_thr),
    .ls_stop_thr  (ls_stop_thr),
    .ls_n_start   (ls_n_start),
    .ls_n_stop    (ls_n_stop),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .busy         (busy),
    .overflow     (overflow)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_start();
    cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({m_tvalid, m_tlast, busy, overflow} !== 4'b0000 || m_tdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tvalid=%b tlast=%b busy=%b ovf=%b tdata=%h, need all 0",
               m_tvalid, m_tlast, busy, overflow, m_tdata);
    end
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic test_single_shot();
    cr_test = 1'b1; cr_rt = 1'b0; cr_ls = 1'b0; dsize = 32'd4; m_tready = 1'b1;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_after_start: got %b need 1", busy);
    end
    for (int i = 0; i < 4; i++) begin
      send(16'hAAAA);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 16'(i) || m_tlast !== (i == 3)) begin
        n_fail++;
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b need v=1 d=%h l=%b",
                 i, m_tvalid, m_tdata, m_tlast, 16'(i), (i == 3));
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_end: got %b need 0", busy);
    end
    repeat (2) tick();
  endtask

  task automatic test_continuous();
    cr_test = 1'b1; cr_rt = 1'b1; cr_ls = 1'b0; dsize = 32'd3; m_tready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 9; i++) begin
      send(16'h0);
      if (i == 7) cr_rt = 1'b0;
      n_checks++;
      if (m_tdata !== 16'(i - 1) || m_tlast !== (i % 3 == 0)) begin
        n_fail++;
        $display("FAIL rt_beat%0d: got d=%h l=%b need d=%h l=%b",
                 i, m_tdata, m_tlast, 16'(i - 1), (i % 3 == 0));
      end
      if (i == 6 || i == 9) begin
        n_checks++;
        if (busy !== (i == 6)) begin
          n_fail++; $display("FAIL rt_busy_after%0d: got %b need %b", i, busy, (i == 6));
        end
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_ls_trigger();
    logic [15:0] arm_vec [6] = '{16'd50, 16'd120, 16'd130, 16'd90, 16'd110, 16'd120};
    cr_test = 1'b0; cr_rt = 1'b0; cr_ls = 1'b1; dsize = 32'd2;
    ls_start_thr = 16'd100; ls_n_start = 32'd3; ls_stop_thr = 16'd0; ls_n_stop = 32'd1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(arm_vec[i]);
      n_checks++;
      if (m_tvalid !== 1'b0) begin
        n_fail++; $display("FAIL ls_arm_silent%0d: got tvalid=%b need 0", i, m_tvalid);
      end
    end
    send(16'd140);
    n_checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'd140 || m_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL ls_first_beat: got v=%b d=%0d l=%b need v=1 d=140 l=0", m_tvalid, m_tdata, m_tlast);
    end
    send(16'd150);
    n_checks++;
    if (m_tdata !== 16'd150 || m_tlast !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ls_second_beat: got d=%0d l=%b busy=%b need d=150 l=1 busy=0", m_tdata, m_tlast, busy);
    end
    repeat (2) tick();
  endtask

  task automatic test_ls_stop();
    logic [15:0] vec [4] = '{16'd20, 16'd20, 16'd5, 16'd3};
    cr_test = 1'b0; cr_rt = 1'b0; cr_ls = 1'b1; dsize = 32'd100;
    ls_start_thr = 16'd0; ls_n_start = 32'd1; ls_stop_thr = 16'd10; ls_n_stop = 32'd2;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(vec[i]);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== vec[i] || m_tlast !== (i == 3)) begin
        n_fail++;
        $display("FAIL ls_stop_beat%0d: got v=%b d=%0d l=%b need v=1 d=%0d l=%b",
                 i, m_tvalid, m_tdata, m_tlast, vec[i], (i == 3));
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL ls_stop_idle: got busy=%b need 0", busy);
    end
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    cr_test = 1'b1; cr_rt = 1'b0; cr_ls = 1'b0; dsize = 32'd8; m_tready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send(16'h0);
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 16'd0 || overflow !== (i > 0)) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%h ovf=%b need v=1 d=0 ovf=%b",
                 i, m_tvalid, m_tdata, overflow, (i > 0));
      end
    end
    m_tready = 1'b1;
    tick();
    n_checks++;
    if (m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: got tvalid=%b need 0", m_tvalid);
    end
    for (int i = 3; i < 8; i++) begin
      send(16'h0);
      n_checks++;
      if (m_tdata !== 16'(i) || m_tlast !== (i == 7) || overflow !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got d=%h l=%b ovf=%b need d=%h l=%b ovf=1",
                 i, m_tdata, m_tlast, overflow, 16'(i), (i == 7));
      end
    end
    tick();
    pulse_start();
    n_checks++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_ovf_clear: got ovf=%b busy=%b need ovf=0 busy=1", overflow, busy);
    end
  endtask

  task automatic test_async_reset();
    // Still capturing from the previous task; stall output so tvalid is held
    m_tready = 1'b0;
    send(16'h0);
    n_checks++;
    if (m_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got tvalid=%b need 1", m_tvalid);
    end
    #2 ARESETN = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL areset_immediate: got tvalid=%b busy=%b need 0 0", m_tvalid, busy);
    end
    tick();
    ARESETN = 1'b1;
    m_tready = 1'b1;
    tick();
    dsize = 32'd0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL dsize0_ignored: got busy=%b need 0", busy);
    end
  endtask

  task automatic test_start_while_busy();
    cr_test = 1'b1; cr_rt = 1'b0; cr_ls = 1'b0; dsize = 32'd3; m_tready = 1'b1;
    pulse_start();
    send(16'h0);
    pulse_start();
    send(16'h0);
    n_checks++;
    if (m_tdata !== 16'd1 || m_tlast !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_ignored: got d=%h l=%b need d=1 l=0", m_tdata, m_tlast);
    end
    send(16'h0);
    n_checks++;
    if (m_tdata !== 16'd2 || m_tlast !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_end: got d=%h l=%b busy=%b need d=2 l=1 busy=0", m_tdata, m_tlast, busy);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_ls_trigger();
    test_ls_stop();
    test_backpressure();
    test_async_reset();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
